// File: rtl/mem_port_arbiter.sv
// Arbiter that shares one fixed-latency, single-ported memory between instruction
// fetch and data access, with D priority bounded by an I-starvation limit.
module mem_port_arbiter #(
  parameter int WORD_W       = 16,
  parameter int LATENCY      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [WORD_W-1:0] i_addr,
  input  logic              i_flush,
  output logic [WORD_W-1:0] i_data,
  output logic              i_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [WORD_W-1:0] d_addr,
  input  logic [WORD_W-1:0] d_wdata,
  output logic [WORD_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int STK_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [STK_W-1:0] STK_MAX  = STK_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [STK_W-1:0]    r_streak;
  logic                r_discard;
  logic                r_owner_d;
  logic                r_we;
  logic [WORD_W-1:0]   r_i_data;
  logic [WORD_W-1:0]   r_d_rdata;
  logic                r_i_ready;
  logic                r_d_ready;
  logic                r_mem_read;
  logic                r_mem_write;
  logic [WORD_W-1:0]   r_mem_addr;
  logic [WORD_W-1:0]   r_mem_wdata;

  logic w_i_pend;
  logic w_starved;
  logic w_grant_d;
  logic w_grant_i;

  function automatic logic [STK_W-1:0] sat_inc(input logic [STK_W-1:0] v);
    return (v == STK_MAX) ? v : v + 1'b1;
  endfunction

  // A flushed fetch is not pending; D wins unless I has waited STARVE_LIMIT D grants.
  assign w_i_pend  = i_req && !i_flush;
  assign w_starved = w_i_pend && (r_streak == STK_MAX);
  assign w_grant_d = d_req && !w_starved;
  assign w_grant_i = !w_grant_d && w_i_pend;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_streak    <= '0;
      r_discard   <= 1'b0;
      r_owner_d   <= 1'b0;
      r_we        <= 1'b0;
      r_i_data    <= '0;
      r_d_rdata   <= '0;
      r_i_ready   <= 1'b0;
      r_d_ready   <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_i_ready <= 1'b0;
          r_d_ready <= 1'b0;
          if (w_grant_d) begin
            r_state     <= S_ACCESS;
            r_cnt       <= CNT_LOAD;
            r_discard   <= 1'b0;
            r_owner_d   <= 1'b1;
            r_we        <= d_we;
            r_mem_read  <= !d_we;
            r_mem_write <= d_we;
            r_mem_addr  <= d_addr;
            r_mem_wdata <= d_wdata;
            r_streak    <= w_i_pend ? sat_inc(r_streak) : '0;
          end else if (w_grant_i) begin
            r_state     <= S_ACCESS;
            r_cnt       <= CNT_LOAD;
            r_discard   <= 1'b0;
            r_owner_d   <= 1'b0;
            r_we        <= 1'b0;
            r_mem_read  <= 1'b1;
            r_mem_write <= 1'b0;
            r_mem_addr  <= i_addr;
            r_mem_wdata <= '0;
            r_streak    <= '0;
          end
        end
        S_ACCESS: begin
          if (!r_owner_d && i_flush) begin
            r_discard <= 1'b1;
          end
          if (r_cnt == '0) begin
            r_state     <= S_DONE;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            if (r_owner_d) begin
              r_d_rdata <= mem_rdata;
              r_d_ready <= 1'b1;
            end else if (!(r_discard || i_flush)) begin
              // A flush in the final access cycle still squashes the result.
              r_i_data  <= mem_rdata;
              r_i_ready <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE: begin
          r_state   <= S_IDLE;
          r_i_ready <= 1'b0;
          r_d_ready <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign i_data    = r_i_data;
  assign i_ready   = r_i_ready;
  assign d_rdata   = r_d_rdata;
  assign d_ready   = r_d_ready;
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule
